// File: rtl/video_timing_tpg.sv
// video_timing_tpg: parametrised raster timing generator (DE/HSYNC/VSYNC)
// with a built-in test-pattern generator (solid, colour bars, gradient,
// checkerboard). Run/stop control always completes the current frame.
// Pattern selection is shadow-latched when the frame starts.
// Optional macro TPG_SCROLL_EN: an 8-bit frame counter scrolls the gradient
// and checkerboard by one pixel per frame.
module video_timing_tpg #(
  parameter int H_RES    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_RES    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 12,
  parameter int CHK_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       pattern,
  input  logic [23:0]      solid_rgb,
  output logic             hdmi_de,
  output logic             hdmi_hs,
  output logic             hdmi_vs,
  output logic [7:0]       hdmi_r,
  output logic [7:0]       hdmi_g,
  output logic [7:0]       hdmi_b,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             busy
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_RES);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_RES + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_RES + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_RES);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_RES + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_RES + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_RES / 8 - 1);
  localparam logic             HS_ACT   = 1'(HS_POL);
  localparam logic             VS_ACT   = 1'(VS_POL);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar_idx;
  logic [1:0]       pat_q;
  logic [23:0]      rgb_q;
  logic [7:0]       frame_cnt;

  logic             running, h_wrap, frame_end;
  logic             de_raw, hs_raw, vs_raw;
  logic [7:0]       x8;
  logic [23:0]      colour;

  assign running   = (state != IDLE);
  assign h_wrap    = (hcnt == H_LAST);
  assign frame_end = h_wrap && (vcnt == V_LAST);

  // Frame state, raster counters, bar counter and frame-start shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      pat_q     <= '0;
      rgb_q     <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= RUN;
            pat_q <= pattern;
            rgb_q <= solid_rgb;
          end
        end
        default: begin
          if (h_wrap) begin
            hcnt    <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            if (frame_end) begin
              vcnt      <= '0;
              pat_q     <= pattern;
              rgb_q     <= solid_rgb;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              vcnt <= vcnt + 1'b1;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
            if (hcnt < H_ACT) begin
              if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
              end else begin
                bar_cnt <= bar_cnt + 1'b1;
              end
            end
          end
          // run has priority so a re-raise on the last clock keeps running
          if (run)
            state <= RUN;
          else if (state == STOPPING && frame_end)
            state <= IDLE;
          else
            state <= STOPPING;
        end
      endcase
    end
  end

  // Raw timing and pattern colour for the current counter position
  always_comb begin
    de_raw = running && (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_raw = running && (hcnt >= HS_BEG) && (hcnt < HS_END);
    vs_raw = running && (vcnt >= VS_BEG) && (vcnt < VS_END);
`ifdef TPG_SCROLL_EN
    x8 = hcnt[7:0] + frame_cnt;
`else
    x8 = hcnt[7:0];
`endif
    colour = '0;
    case (pat_q)
      2'd0: colour = rgb_q;
      2'd1: colour = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      2'd2: colour = {x8, x8, x8};
      default: colour = (x8[CHK_LOG2] ^ vcnt[CHK_LOG2]) ? '0 : '1;
    endcase
  end

  // Single output register stage keeping every output aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdmi_de     <= 1'b0;
      hdmi_hs     <= ~HS_ACT;
      hdmi_vs     <= ~VS_ACT;
      hdmi_r      <= '0;
      hdmi_g      <= '0;
      hdmi_b      <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      hdmi_de     <= de_raw;
      hdmi_hs     <= hs_raw ? HS_ACT : ~HS_ACT;
      hdmi_vs     <= vs_raw ? VS_ACT : ~VS_ACT;
      hdmi_r      <= de_raw ? colour[23:16] : '0;
      hdmi_g      <= de_raw ? colour[15:8]  : '0;
      hdmi_b      <= de_raw ? colour[7:0]   : '0;
      pix_x       <= hcnt;
      pix_y       <= vcnt;
      frame_start <= running && (hcnt == '0) && (vcnt == '0);
      busy        <= running;
    end
  end

endmodule

// File: tb/tb_video_timing_tpg.sv
// tb_video_timing_tpg: directed and randomized stimulus against a
// frame-position reference model (linear pixel index within the frame).
module tb_video_timing_tpg;

  localparam int HR = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VR = 4,  VF = 1, VSY = 2, VB = 1;
  localparam int HT = HR + HF + HSY + HB;
  localparam int VT = VR + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int CHK = 1;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst, run;
  logic [1:0]  pattern;
  logic [23:0] solid_rgb;

  logic de, hs, vs, fs, busy;
  logic [7:0] r, g, b;
  logic [CW-1:0] px, py;

  logic de2, hs2, vs2, fs2, busy2;
  logic [7:0] r2, g2, b2;
  logic [CW-1:0] px2, py2;

  always #5 clk = ~clk;

  video_timing_tpg #(
    .H_RES(HR), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_RES(VR), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .CNT_W(CW), .CHK_LOG2(CHK)
  ) u_dut (
    .clk(clk), .rst(rst), .run(run), .pattern(pattern), .solid_rgb(solid_rgb),
    .hdmi_de(de), .hdmi_hs(hs), .hdmi_vs(vs),
    .hdmi_r(r), .hdmi_g(g), .hdmi_b(b),
    .pix_x(px), .pix_y(py), .frame_start(fs), .busy(busy)
  );

  video_timing_tpg #(
    .H_RES(HR), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_RES(VR), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .CNT_W(CW), .CHK_LOG2(CHK)
  ) u_dut_inv (
    .clk(clk), .rst(rst), .run(run), .pattern(pattern), .solid_rgb(solid_rgb),
    .hdmi_de(de2), .hdmi_hs(hs2), .hdmi_vs(vs2),
    .hdmi_r(r2), .hdmi_g(g2), .hdmi_b(b2),
    .pix_x(px2), .pix_y(py2), .frame_start(fs2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: 0 idle, 1 running, 2 stopping; p = pixel index in frame
  int          m_state;
  int          m_p;
  logic [1:0]  m_pat;
  logic [23:0] m_rgb;
  logic [7:0]  m_fc;

  logic        e_de, e_hs, e_vs, e_fs, e_busy;
  logic [23:0] e_rgb;
  int          e_px, e_py;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] colour_of(int x, int y);
    int xs;
    logic [7:0] v;
    xs = x;
`ifdef TPG_SCROLL_EN
    xs = x + int'(m_fc);
`endif
    v = 8'(xs);
    case (m_pat)
      2'd0: return m_rgb;
      2'd1: return bars[x / (HR / 8)];
      2'd2: return {v, v, v};
      default: return ((((xs >> CHK) & 1) ^ ((y >> CHK) & 1)) != 0) ? 24'h000000 : 24'hFFFFFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_p = 0; m_pat = '0; m_rgb = '0; m_fc = '0;
  endtask

  task automatic model_outputs();
    int x, y;
    e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_busy = 0; e_rgb = '0; e_px = 0; e_py = 0;
    if (!rst && m_state != 0) begin
      x = m_p % HT;
      y = m_p / HT;
      e_busy = 1;
      e_de = (x < HR) && (y < VR);
      e_hs = !((x >= HR + HF) && (x < HR + HF + HSY));
      e_vs = !((y >= VR + VF) && (y < VR + VF + VSY));
      e_fs = (m_p == 0);
      e_rgb = e_de ? colour_of(x, y) : 24'h0;
      e_px = x;
      e_py = y;
    end
  endtask

  task automatic model_step();
    logic wrap;
    if (rst) begin
      model_reset();
    end else if (m_state == 0) begin
      if (run) begin
        m_state = 1; m_p = 0; m_pat = pattern; m_rgb = solid_rgb;
      end
    end else begin
      wrap = (m_p == FRAME - 1);
      m_p = (m_p + 1) % FRAME;
      if (wrap) begin
        m_pat = pattern; m_rgb = solid_rgb; m_fc = m_fc + 8'd1;
      end
      if (run) m_state = 1;
      else if (m_state == 2 && wrap) begin m_state = 0; m_p = 0; end
      else m_state = 2;
    end
  endtask

  task automatic check_outputs();
    chk("de", 32'(de), 32'(e_de));
    chk("hs", 32'(hs), 32'(e_hs));
    chk("vs", 32'(vs), 32'(e_vs));
    chk("hs_inv", 32'(hs2), 32'(!e_hs));
    chk("vs_inv", 32'(vs2), 32'(!e_vs));
    chk("rgb", 32'({r, g, b}), 32'(e_rgb));
    chk("frame_start", 32'(fs), 32'(e_fs));
    chk("busy", 32'(busy), 32'(e_busy));
    if (e_de) begin
      chk("pix_x", 32'(px), 32'(e_px));
      chk("pix_y", 32'(py), 32'(e_py));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_outputs();
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_de"}, 32'(de), 32'(0));
    chk({tag, "_hs"}, 32'(hs), 32'(1));
    chk({tag, "_vs"}, 32'(vs), 32'(1));
    chk({tag, "_hs_inv"}, 32'(hs2), 32'(0));
    chk({tag, "_vs_inv"}, 32'(vs2), 32'(0));
    chk({tag, "_rgb"}, 32'({r, g, b}), 32'(0));
    chk({tag, "_pix_x"}, 32'(px), 32'(0));
    chk({tag, "_pix_y"}, 32'(py), 32'(0));
    chk({tag, "_fs"}, 32'(fs), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int cnt_de, cnt_fs, cnt_hs, cnt_vs, guard;
    rst = 1'b1; run = 1'b0; pattern = 2'd0; solid_rgb = 24'h0;
    model_reset();
    repeat (2) cyc();
    check_reset_values("reset");
    rst = 1'b0;
    repeat (3) cyc();

    // colour bars, frame-level counts over one full frame
    pattern = 2'd1; run = 1'b1;
    repeat (3) cyc();
    cnt_de = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      cnt_de += int'(de); cnt_fs += int'(fs);
      cnt_hs += int'(!hs); cnt_vs += int'(!vs);
    end
    chk("de_per_frame", 32'(cnt_de), 32'(HR * VR));
    chk("fs_per_frame", 32'(cnt_fs), 32'(1));
    chk("hs_per_frame", 32'(cnt_hs), 32'(HSY * VT));
    chk("vs_per_frame", 32'(cnt_vs), 32'(VSY * HT));

    // solid colour, switched to checkerboard mid-frame
    pattern = 2'd0; solid_rgb = 24'h3C5A96;
    guard = 0;
    do begin cyc(); guard++; end while (!(m_state != 0 && m_p == 0) && guard < 2 * FRAME);
    chk("wait_frame0", 32'(guard < 2 * FRAME), 32'(1));
    repeat (50) cyc();
    pattern = 2'd3; solid_rgb = 24'h123456;
    repeat (2 * FRAME) cyc();

    // drop run during line 1; frame completes then idles
    guard = 0;
    do begin cyc(); guard++; end while (m_p != HT + 5 && guard < 2 * FRAME);
    run = 1'b0;
    guard = 0;
    do begin cyc(); guard++; end while (busy && guard < 2 * FRAME);
    chk("stop_to_idle", 32'(busy), 32'(0));
    repeat (20) cyc();

    // restart, stop mid-frame, re-raise before frame end: no gap
    run = 1'b1; pattern = 2'd2;
    repeat (FRAME / 2) cyc();
    run = 1'b0;
    repeat (30) cyc();
    run = 1'b1;
    guard = 0;
    do begin cyc(); guard++; end while (!fs && guard < 2 * FRAME);
    cnt_fs = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      cnt_fs += int'(fs);
    end
    chk("fs_no_gap", 32'(cnt_fs), 32'(2));

    // randomized patterns, colours and run control
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(59, 0) == 0) pattern = 2'($urandom);
      if ($urandom_range(59, 0) == 0) solid_rgb = 24'($urandom);
      if ($urandom_range(299, 0) == 0) run = ~run;
      cyc();
    end

    // asynchronous reset in the middle of an active line
    run = 1'b1;
    guard = 0;
    do begin cyc(); guard++; end while (!(m_state != 0 && (m_p % HT) == 7 && (m_p / HT) == 1) && guard < 3 * FRAME);
    chk("wait_midline", 32'(guard < 3 * FRAME), 32'(1));
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    model_reset();
    repeat (2) cyc();
    rst = 1'b0; pattern = 2'd2;
    repeat (3 * FRAME + 10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
